// File: rtl/fm_step4.sv
// fm_step4 - normalize / round / pack stage of the floating-point multiplier.
//
// Takes the raw 22-bit product, its leading-one index, sign and biased
// exponent from the product summation stage. It shifts the product into 1.f
// form, adjusts the exponent, optionally rounds to nearest-even and packs a
// sign / 8-bit exponent / 10-bit fraction result. This is a 2-stage pipeline:
// stage A normalizes, and stage B rounds, packs and drives the outputs from flops.
//
// Configuration:
//   FM_STEP4_ROUND_EN  defined   -> round to nearest-even, including carry into the exponent
//                      undefined -> truncation (guard/sticky ignored)
//   SAT_INF (param)    1 -> overflow gives infinity (255, 0)
//                      0 -> overflow gives max finite (254, 3FF)
//
// Ports:
//   CLK, RESET           clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  upstream handshake
//   in_sign, in_ex       product sign, biased exponent (binary point between in_mul[20] and [19])
//   in_mul, in_count     raw product, index of its leading one (21 when in_mul is 0)
//   out_valid / out_ready downstream handshake
//   out_sign, out_ex, out_frac  packed result (hidden bit dropped)
//   out_ovf, out_unf     overflow / underflow-or-flush flags
//
// Handshake: a word moves across a boundary on a clock edge where valid and
// ready are both high. valid never depends on ready. While valid is high and
// ready is low, the producer holds its data stable. in_ready is combinational
// from out_ready and the stage valid bits. All out_* signals come straight from flops.

module fm_step4 #(
    parameter int SAT_INF = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_ex,
    input  logic [21:0] in_mul,
    input  logic [4:0]  in_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_ex,
    output logic [9:0]  out_frac,
    output logic        out_ovf,
    output logic        out_unf
);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic r_a_valid;
    logic r_b_valid;
    logic w_load_a;
    logic w_load_b;

    // Stage B takes a new word when it is empty or its word leaves this cycle.
    assign w_load_b = !r_b_valid | out_ready;
    // Stage A takes a new word when it is empty or its word advances into B.
    assign w_load_a = !r_a_valid | w_load_b;
    assign in_ready = w_load_a;

    // ------------------------------------------------------------------
    // Stage A: normalize
    // ------------------------------------------------------------------
    logic [4:0]        w_cnt;
    logic [4:0]        w_sh;
    logic [21:0]       w_m;
    logic              w_zero;
    logic signed [9:0] w_e;
    logic [9:0]        w_frac;
    logic              w_guard;
    logic              w_sticky;

    // Leading-one indices above 21 cannot occur in a 22-bit product; they
    // are folded onto the "product >= 2" case.
    assign w_cnt  = (in_count > 5'd21) ? 5'd21 : in_count;
    assign w_sh   = 5'd20 - w_cnt;   // only meaningful when w_cnt <= 20
    assign w_m    = in_mul << w_sh;
    assign w_zero = (in_mul == 22'd0);

    always_comb begin
        w_e      = '0;
        w_frac   = in_mul[20:11];
        w_guard  = in_mul[10];
        w_sticky = |in_mul[9:0];
        if (w_zero) begin
            w_frac   = '0;
            w_guard  = 1'b0;
            w_sticky = 1'b0;
        end else if (w_cnt == 5'd21) begin
            // Product in [2,4): drop one more bit and bump the exponent.
            w_e = $signed({2'b00, in_ex}) + 10'sd1;
        end else begin
            // Leading one now sits at bit 20, so the fraction starts at bit 19.
            w_e      = $signed({2'b00, in_ex}) - $signed({5'b00000, w_sh});
            w_frac   = w_m[19:10];
            w_guard  = w_m[9];
            w_sticky = |w_m[8:0];
        end
    end

    // The leading one is shifted to bit 20, so the two top bits carry nothing.
    logic [1:0] w_unused_m;
    assign w_unused_m = w_m[21:20];

    logic              r_a_sign;
    logic              r_a_zero;
    logic              r_a_guard;
    logic              r_a_sticky;
    logic [9:0]        r_a_frac;
    logic signed [9:0] r_a_e;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_a_valid <= 1'b0;
        end else if (w_load_a) begin
            r_a_valid <= in_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_load_a && in_valid) begin
            r_a_sign   <= in_sign;
            r_a_zero   <= w_zero;
            r_a_e      <= w_e;
            r_a_frac   <= w_frac;
            r_a_guard  <= w_guard;
            r_a_sticky <= w_sticky;
        end
    end

    // ------------------------------------------------------------------
    // Stage B: round, range check, pack
    // ------------------------------------------------------------------
    logic [9:0]        w_rfrac;
    logic signed [9:0] w_re;

`ifdef FM_STEP4_ROUND_EN
    logic        w_round_up;
    logic [10:0] w_frac_sum;

    // Nearest-even: round up above half, or at exactly half when the fraction is odd.
    assign w_round_up = r_a_guard & (r_a_sticky | r_a_frac[0]);
    assign w_frac_sum = {1'b0, r_a_frac} + {10'd0, w_round_up};
    // A carry out of the fraction leaves it at zero (1.0 x 2^(e+1)).
    assign w_rfrac    = w_frac_sum[9:0];
    assign w_re       = r_a_e + $signed({9'd0, w_frac_sum[10]});
`else
    logic w_unused_round;
    assign w_unused_round = r_a_guard ^ r_a_sticky;
    assign w_rfrac        = r_a_frac;
    assign w_re           = r_a_e;
`endif

    logic [7:0] w_b_ex;
    logic [9:0] w_b_frac;
    logic       w_b_ovf;
    logic       w_b_unf;

    always_comb begin
        w_b_ex   = '0;
        w_b_frac = '0;
        w_b_ovf  = 1'b0;
        w_b_unf  = 1'b0;
        if (r_a_zero) begin
            // Exact zero: all fields stay at zero and no flags are raised.
            w_b_ex = '0;
        end else if (w_re >= 10'sd255) begin
            w_b_ovf  = 1'b1;
            w_b_ex   = (SAT_INF != 0) ? 8'd255 : 8'd254;
            w_b_frac = (SAT_INF != 0) ? 10'h000 : 10'h3FF;
        end else if (w_re <= 10'sd0) begin
            // No denormals: flush to signed zero.
            w_b_unf = 1'b1;
        end else begin
            w_b_ex   = w_re[7:0];
            w_b_frac = w_rfrac;
        end
    end

    logic       r_b_sign;
    logic [7:0] r_b_ex;
    logic [9:0] r_b_frac;
    logic       r_b_ovf;
    logic       r_b_unf;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_b_valid <= 1'b0;
            r_b_sign  <= 1'b0;
            r_b_ex    <= '0;
            r_b_frac  <= '0;
            r_b_ovf   <= 1'b0;
            r_b_unf   <= 1'b0;
        end else if (w_load_b) begin
            r_b_valid <= r_a_valid;
            // Keep the last result on the outputs when nothing new arrives.
            if (r_a_valid) begin
                r_b_sign <= r_a_sign;
                r_b_ex   <= w_b_ex;
                r_b_frac <= w_b_frac;
                r_b_ovf  <= w_b_ovf;
                r_b_unf  <= w_b_unf;
            end
        end
    end

    assign out_valid = r_b_valid;
    assign out_sign  = r_b_sign;
    assign out_ex    = r_b_ex;
    assign out_frac  = r_b_frac;
    assign out_ovf   = r_b_ovf;
    assign out_unf   = r_b_unf;

endmodule

// File: tb/tb_fm_step4.sv
// tb_fm_step4 - directed bench for fm_step4 (default SAT_INF=1 plus a SAT_INF=0 copy).
// Result words are packed as {sign, ex[7:0], frac[9:0], ovf, unf}.

module tb_fm_step4;

    logic        CLK;
    logic        RESET;
    logic        in_valid;
    logic        in_sign;
    logic [7:0]  in_ex;
    logic [21:0] in_mul;
    logic [4:0]  in_count;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic        out_sign;
    logic [7:0]  out_ex;
    logic [9:0]  out_frac;
    logic        out_ovf;
    logic        out_unf;

    logic        d2_in_ready;
    logic        d2_out_valid;
    logic        d2_out_sign;
    logic [7:0]  d2_out_ex;
    logic [9:0]  d2_out_frac;
    logic        d2_out_ovf;
    logic        d2_out_unf;

    logic [20:0] obs;
    logic [20:0] obs2;
    logic [20:0] exp_q[$];
    logic [20:0] mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    assign obs  = {out_sign, out_ex, out_frac, out_ovf, out_unf};
    assign obs2 = {d2_out_sign, d2_out_ex, d2_out_frac, d2_out_ovf, d2_out_unf};

    fm_step4 u_dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_ex(in_ex), .in_mul(in_mul), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_ex(out_ex), .out_frac(out_frac),
        .out_ovf(out_ovf), .out_unf(out_unf)
    );

    fm_step4 #(.SAT_INF(0)) u_dut_sat0 (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_sign(in_sign), .in_ex(in_ex), .in_mul(in_mul), .in_count(in_count),
        .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_sign(d2_out_sign), .out_ex(d2_out_ex), .out_frac(d2_out_frac),
        .out_ovf(d2_out_ovf), .out_unf(d2_out_unf)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [20:0] pk(input logic s, input logic [7:0] ex,
                                       input logic [9:0] fr, input logic ov, input logic un);
        return {s, ex, fr, ov, un};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the word is accepted.
    task automatic send(input logic s, input logic [7:0] ex, input logic [21:0] mul,
                        input logic [4:0] cnt, input logic [20:0] e, input bit push);
        bit done;
        int waited;
        done   = 0;
        waited = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_ex    = ex;
        in_mul   = mul;
        in_count = cnt;
        while (!done && waited < 100) begin
            @(negedge CLK);
            if (in_ready) begin
                done = 1;
                if (push) exp_q.push_back(e);
            end else begin
                waited++;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // Single word through an empty pipe with out_ready high: valid two cycles
    // after the handshake cycle, then compare both instances.
    task automatic run_one(input string tag, input logic s, input logic [7:0] ex,
                           input logic [21:0] mul, input logic [4:0] cnt,
                           input logic [20:0] e1, input logic [20:0] e2);
        send(s, ex, mul, cnt, e1, 1'b1);
        @(negedge CLK);
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge CLK);
        check({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
        check(tag, {11'd0, obs}, {11'd0, e1});
        check({tag, "_sat0"}, {11'd0, obs2}, {11'd0, e2});
        @(posedge CLK);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (!RESET && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_out", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon", {11'd0, obs}, {11'd0, mon_e});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        RESET     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_ex     = '0;
        in_mul    = '0;
        in_count  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", {11'd0, obs}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        run_one("norm21", 1'b1, 8'd130, 22'h200000, 5'd21, pk(1, 131, 10'h000, 0, 0), pk(1, 131, 10'h000, 0, 0));
`ifdef FM_STEP4_ROUND_EN
        run_one("tie_even", 1'b0, 8'd127, 22'h100600, 5'd20, pk(0, 127, 10'h002, 0, 0), pk(0, 127, 10'h002, 0, 0));
        run_one("carry_ovf", 1'b0, 8'd254, 22'h1FFE00, 5'd20, pk(0, 255, 10'h000, 1, 0), pk(0, 254, 10'h3FF, 1, 0));
        run_one("carry_exp", 1'b0, 8'd100, 22'h1FFE00, 5'd20, pk(0, 101, 10'h000, 0, 0), pk(0, 101, 10'h000, 0, 0));
        run_one("odd_round", 1'b1, 8'd50, 22'h000C03, 5'd11, pk(1, 41, 10'h202, 0, 0), pk(1, 41, 10'h202, 0, 0));
        run_one("sticky_rnd", 1'b0, 8'd50, 22'h001803, 5'd12, pk(0, 42, 10'h201, 0, 0), pk(0, 42, 10'h201, 0, 0));
`else
        run_one("tie_even", 1'b0, 8'd127, 22'h100600, 5'd20, pk(0, 127, 10'h001, 0, 0), pk(0, 127, 10'h001, 0, 0));
        run_one("carry_ovf", 1'b0, 8'd254, 22'h1FFE00, 5'd20, pk(0, 254, 10'h3FF, 0, 0), pk(0, 254, 10'h3FF, 0, 0));
        run_one("carry_exp", 1'b0, 8'd100, 22'h1FFE00, 5'd20, pk(0, 100, 10'h3FF, 0, 0), pk(0, 100, 10'h3FF, 0, 0));
        run_one("odd_round", 1'b1, 8'd50, 22'h000C03, 5'd11, pk(1, 41, 10'h201, 0, 0), pk(1, 41, 10'h201, 0, 0));
        run_one("sticky_rnd", 1'b0, 8'd50, 22'h001803, 5'd12, pk(0, 42, 10'h200, 0, 0), pk(0, 42, 10'h200, 0, 0));
`endif
        run_one("ovf_plain", 1'b0, 8'd254, 22'h200000, 5'd21, pk(0, 255, 10'h000, 1, 0), pk(0, 254, 10'h3FF, 1, 0));
        run_one("unf", 1'b1, 8'd2, 22'h040000, 5'd18, pk(1, 0, 10'h000, 0, 1), pk(1, 0, 10'h000, 0, 1));
        run_one("zero", 1'b1, 8'd100, 22'h000000, 5'd21, pk(1, 0, 10'h000, 0, 0), pk(1, 0, 10'h000, 0, 0));
        run_one("cnt_clamp", 1'b0, 8'd10, 22'h300400, 5'd25, pk(0, 11, 10'h200, 0, 0), pk(0, 11, 10'h200, 0, 0));
        run_one("e_one", 1'b0, 8'd1, 22'h100000, 5'd20, pk(0, 1, 10'h000, 0, 0), pk(0, 1, 10'h000, 0, 0));
        run_one("e_zero", 1'b0, 8'd1, 22'h080000, 5'd19, pk(0, 0, 10'h000, 0, 1), pk(0, 0, 10'h000, 0, 1));
        run_one("e_254", 1'b0, 8'd254, 22'h100000, 5'd20, pk(0, 254, 10'h000, 0, 0), pk(0, 254, 10'h000, 0, 0));
        run_one("max_shift", 1'b0, 8'd30, 22'h000001, 5'd0, pk(0, 10, 10'h000, 0, 0), pk(0, 10, 10'h000, 0, 0));

        // ---- backpressure: 6 back-to-back words, out_ready low for 4 cycles ----
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(i[0], 8'(100 + i), 22'h100000 | 22'(i << 10), 5'd20,
                         pk(i[0], 8'(100 + i), 10'(i), 0, 0), 1'b1);
                end
            end
            begin
                repeat (2) @(negedge CLK);
                for (int k = 0; k < 4; k++) begin
                    @(negedge CLK);
                    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                    check("bp_stable", {11'd0, obs}, {11'd0, pk(0, 100, 10'h000, 0, 0)});
                end
                @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge CLK);
        check("bp_drain", exp_q.size(), 32'd0);
        @(posedge CLK);
        #1;
        check("bp_nodup", {31'd0, out_valid}, 32'd0);

        // ---- reset with two words in flight ----
        out_ready = 1'b0;
        send(1'b1, 8'd90, 22'h3FFFFF, 5'd21, '0, 1'b0);
        send(1'b1, 8'd91, 22'h155555, 5'd20, '0, 1'b0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_word", {11'd0, obs}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        run_one("post_rst", 1'b0, 8'd127, 22'h100000, 5'd20, pk(0, 127, 10'h000, 0, 0), pk(0, 127, 10'h000, 0, 0));
        repeat (3) @(negedge CLK);
        check("final_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
